// File: rtl/mem_read_arbiter.sv
// Arbitrates N_REQ cache requesters onto one memory read port, one transaction at a time.
// Define MEM_READ_ARBITER_RR_EN for round-robin arbitration (default: highest index wins).
module mem_read_arbiter #(
  parameter  int unsigned ADDR_WIDTH = 64,
  parameter  int unsigned DATA_WIDTH = 64,
  parameter  int unsigned N_REQ      = 2,
  localparam int unsigned GNT_W      = $clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [N_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]       resp_data,
  output logic                        busy,
  output logic [GNT_W-1:0]            gnt_id,
  output logic [ADDR_WIDTH-1:0]       mem_read_addr,
  output logic                        mem_read_valid,
  input  logic [DATA_WIDTH-1:0]       mem_read_data,
  input  logic                        mem_read_ready
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  state_e                state, state_d;
  logic [GNT_W-1:0]      winner, gnt_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic                  mrv_d;
  logic [N_REQ-1:0]      resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_data_d;
  logic                  busy_d;
  logic [ADDR_WIDTH-1:0] addr_arr [N_REQ];

  // Unpack the flat request address bus
  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign addr_arr[g] = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
  end

`ifdef MEM_READ_ARBITER_RR_EN
  logic [GNT_W-1:0] rr, rr_d;
  logic [GNT_W-1:0] cand;
  logic             found;

  // Round robin: first requester after the last grant, ascending with wrap
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = GNT_W'((32'(rr) + k) % N_REQ);
      if (!found && req_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end
`else
  // Fixed priority: highest index wins
  always_comb begin
    winner = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (req_valid[GNT_W'(i)]) winner = GNT_W'(i);
    end
  end
`endif

  always_comb begin
    state_d      = state;
    gnt_d        = gnt_id;
    addr_d       = mem_read_addr;
    mrv_d        = mem_read_valid;
    resp_valid_d = '0;
    resp_data_d  = resp_data;
`ifdef MEM_READ_ARBITER_RR_EN
    rr_d         = rr;
`endif
    case (state)
      IDLE: begin
        if (|req_valid) begin
          gnt_d   = winner;
          addr_d  = {addr_arr[winner][ADDR_WIDTH-1:3], 3'b000};
          mrv_d   = 1'b1;
          state_d = ISSUE;
`ifdef MEM_READ_ARBITER_RR_EN
          rr_d    = winner;
`endif
        end else begin
          mrv_d = 1'b0;
        end
      end
      ISSUE: begin
        if (mem_read_ready) begin
          resp_data_d  = mem_read_data;
          resp_valid_d = N_REQ'(1) << gnt_id;
          mrv_d        = 1'b0;
          state_d      = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      gnt_id         <= '0;
      mem_read_addr  <= '0;
      mem_read_valid <= 1'b0;
      resp_valid     <= '0;
      resp_data      <= '0;
      busy           <= 1'b0;
`ifdef MEM_READ_ARBITER_RR_EN
      rr             <= '0;
`endif
    end else begin
      state          <= state_d;
      gnt_id         <= gnt_d;
      mem_read_addr  <= addr_d;
      mem_read_valid <= mrv_d;
      resp_valid     <= resp_valid_d;
      resp_data      <= resp_data_d;
      busy           <= busy_d;
`ifdef MEM_READ_ARBITER_RR_EN
      rr             <= rr_d;
`endif
    end
  end

`ifndef SYNTHESIS
  a_resp_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(resp_valid));
  a_addr_stable: assert property (@(posedge clk) disable iff (reset)
                                  (state == ISSUE) |=> $stable(mem_read_addr));
  a_resp_gap:    assert property (@(posedge clk) disable iff (reset)
                                  (|resp_valid) |=> !(|resp_valid));
`endif

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter with a transaction-level reference model checked every cycle.
module tb_mem_read_arbiter;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned N  = 2;
  localparam int unsigned GW = 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N*AW-1:0]   req_addr;
  logic [N-1:0]      resp_valid;
  logic [DW-1:0]     resp_data;
  logic              busy;
  logic [GW-1:0]     gnt_id;
  logic [AW-1:0]     mem_read_addr;
  logic              mem_read_valid;
  logic [DW-1:0]     mem_read_data;
  logic              mem_read_ready;

  int checks = 0;
  int passed = 0;

  mem_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_REQ(N)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .busy(busy), .gnt_id(gnt_id),
    .mem_read_addr(mem_read_addr), .mem_read_valid(mem_read_valid),
    .mem_read_data(mem_read_data), .mem_read_ready(mem_read_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Winner selection written straight from the arbitration rule
  function automatic int pick(input logic [N-1:0] rv, input int last);
    int idx;
`ifdef MEM_READ_ARBITER_RR_EN
    for (int off = 1; off <= int'(N); off++) begin
      idx = (last + off) % int'(N);
      if (rv[idx]) return idx;
    end
`else
    idx = last;
    for (int i = int'(N) - 1; i >= 0; i--) if (rv[i]) return i;
`endif
    return 0;
  endfunction

  // Reference model: a transaction is either waiting on memory, just answered, or absent
  logic [N-1:0]  e_rv   = '0;
  logic [DW-1:0] e_rd   = '0;
  logic          e_mrv  = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [GW-1:0] e_gnt  = '0;
  logic          e_busy = 1'b0;
  int            m_last = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      e_rv = '0; e_rd = '0; e_mrv = 1'b0; e_addr = '0; e_gnt = '0; e_busy = 1'b0; m_last = 0;
    end else begin
      logic [N-1:0] prev_rv;
      int w;
      prev_rv = e_rv;
      e_rv    = '0;
      if (e_mrv) begin
        if (mem_read_ready) begin
          e_rd        = mem_read_data;
          e_rv[e_gnt] = 1'b1;
          e_mrv       = 1'b0;
        end
      end else if (prev_rv == '0 && req_valid != '0) begin
        w      = pick(req_valid, m_last);
        m_last = w;
        e_gnt  = GW'(w);
        e_addr = req_addr[w*AW +: AW] & ~AW'(7);
        e_mrv  = 1'b1;
      end
      e_busy = e_mrv || (e_rv != '0);
    end
  end

  always @(negedge clk) begin
    chk("cyc_resp_valid", 64'(resp_valid), 64'(e_rv));
    chk("cyc_mem_valid", 64'(mem_read_valid), 64'(e_mrv));
    chk("cyc_mem_addr", mem_read_addr, e_addr);
    chk("cyc_gnt_id", 64'(gnt_id), 64'(e_gnt));
    chk("cyc_busy", 64'(busy), 64'(e_busy));
    if (e_rv != '0) chk("cyc_resp_data", resp_data, e_rd);
  end

  int g_ids[$];
  int g_cyc[$];
  int exp_g[4];
  logic prev_mrv;

  initial begin
    reset = 1'b1; req_valid = '0; req_addr = '0; mem_read_ready = 1'b0; mem_read_data = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_mrv", 64'(mem_read_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_gnt", 64'(gnt_id), 0);
    chk("rst_resp", 64'(resp_valid), 0);
    chk("rst_addr", mem_read_addr, 0);
    chk("rst_rdata", resp_data, 0);
    reset = 1'b0;
    step();

    // Single icache miss with slow memory
    req_valid = 2'b01; req_addr[63:0] = 64'h1004;
    step();
    chk("t1_mrv", 64'(mem_read_valid), 1);
    chk("t1_addr", mem_read_addr, 64'h1000);
    chk("t1_busy", 64'(busy), 1);
    repeat (5) begin
      step();
      chk("t1_hold", 64'(mem_read_valid), 1);
    end
    mem_read_ready = 1'b1; mem_read_data = 64'hDEAD_BEEF;
    step();
    chk("t1_resp", 64'(resp_valid), 64'h1);
    chk("t1_rdata", resp_data, 64'hDEAD_BEEF);
    mem_read_ready = 1'b0; req_valid = '0;
    step();
    chk("t1_resp_once", 64'(resp_valid), 0);
    step();

    // Both requesting: dcache first, icache after one bubble
    req_valid = 2'b11; req_addr = {64'h3000, 64'h2000};
    step();
    chk("t2_gnt_a", 64'(gnt_id), 1);
    chk("t2_addr_a", mem_read_addr, 64'h3000);
    mem_read_ready = 1'b1; mem_read_data = 64'h1111;
    step();
    chk("t2_resp_a", 64'(resp_valid), 64'h2);
    mem_read_ready = 1'b0; req_valid = 2'b01;
    step();
    chk("t2_bubble", 64'(mem_read_valid), 0);
    step();
    chk("t2_gnt_b", 64'(gnt_id), 0);
    chk("t2_addr_b", mem_read_addr, 64'h2000);
    mem_read_ready = 1'b1; mem_read_data = 64'h2222;
    step();
    chk("t2_resp_b", 64'(resp_valid), 64'h1);
    mem_read_ready = 1'b0; req_valid = '0;
    step(); step();

    // Both held with immediate ready: grant order and issue spacing
`ifdef MEM_READ_ARBITER_RR_EN
    exp_g = '{1, 0, 1, 0};
`else
    exp_g = '{1, 1, 1, 1};
`endif
    req_valid = 2'b11; req_addr = {64'h5000, 64'h4000};
    mem_read_ready = 1'b1; mem_read_data = 64'h3333;
    prev_mrv = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (mem_read_valid && !prev_mrv) begin
        g_ids.push_back(int'(gnt_id));
        g_cyc.push_back(c);
      end
      prev_mrv = mem_read_valid;
    end
    req_valid = '0; mem_read_ready = 1'b0;
    step(); step();
    chk("t3_count", 64'(g_ids.size()), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t3_grant%0d", i), 64'(g_ids[i]), 64'(exp_g[i]));
    for (int i = 0; i < 3; i++) chk($sformatf("t3_gap%0d", i), 64'(g_cyc[i+1] - g_cyc[i]), 3);

    // Granted requester withdraws during ISSUE
    req_valid = 2'b01; req_addr[63:0] = 64'h400F;
    step();
    chk("t4_addr", mem_read_addr, 64'h4008);
    req_valid = '0; req_addr[63:0] = 64'h9999;
    step();
    chk("t4_stable_a", mem_read_addr, 64'h4008);
    step();
    chk("t4_stable_b", mem_read_addr, 64'h4008);
    chk("t4_mrv", 64'(mem_read_valid), 1);
    mem_read_ready = 1'b1; mem_read_data = 64'hC0FFEE;
    step();
    chk("t4_resp", 64'(resp_valid), 64'h1);
    chk("t4_rdata", resp_data, 64'hC0FFEE);
    mem_read_ready = 1'b0;
    step(); step();

    // Reset in the middle of ISSUE
    req_valid = 2'b10; req_addr[127:64] = 64'h6000;
    step();
    chk("t5_mrv", 64'(mem_read_valid), 1);
    chk("t5_gnt", 64'(gnt_id), 1);
    step();
    #1; reset = 1'b1; req_valid = '0;
    #1;
    chk("t5_rst_mrv", 64'(mem_read_valid), 0);
    chk("t5_rst_addr", mem_read_addr, 0);
    chk("t5_rst_busy", 64'(busy), 0);
    chk("t5_rst_gnt", 64'(gnt_id), 0);
    chk("t5_rst_resp", 64'(resp_valid), 0);
    mem_read_ready = 1'b1; mem_read_data = 64'hBAD;
    step();
    chk("t5_no_resp_a", 64'(resp_valid), 0);
    step();
    chk("t5_no_resp_b", 64'(resp_valid), 0);
    mem_read_ready = 1'b0; reset = 1'b0;
    step();
    chk("t5_idle", 64'(busy), 0);
    req_valid = 2'b01; req_addr[63:0] = 64'h7000;
    step();
    chk("t5_fresh_mrv", 64'(mem_read_valid), 1);
    chk("t5_fresh_addr", mem_read_addr, 64'h7000);
    mem_read_ready = 1'b1; mem_read_data = 64'h7777;
    step();
    chk("t5_fresh_resp", 64'(resp_valid), 64'h1);
    chk("t5_fresh_data", resp_data, 64'h7777);
    mem_read_ready = 1'b0; req_valid = '0;
    step(); step();

    // Stray ready while idle
    mem_read_ready = 1'b1; mem_read_data = 64'hFFFF;
    repeat (3) begin
      step();
      chk("t6_no_resp", 64'(resp_valid), 0);
      chk("t6_idle", 64'(busy), 0);
    end
    mem_read_ready = 1'b0;
    step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mem_read_arbiter.md
Name: mem_read_arbiter

Overview:
- Shares the single memory read port between N_REQ cache requesters (port 0 = icache, port 1 = dcache, higher ports spare).
- Grants one requester at a time and latches its line address.
- Holds the memory request until the memory accepts it, then routes the returned data back to the granted requester as a one-cycle response.
- Sits between the icache/dcache miss FSMs and the memory model.

Parameters:
- ADDR_WIDTH, 64, address width on requester and memory sides.
- DATA_WIDTH, 64, data width of one memory read beat.
- N_REQ, 2, number of requesters; legal range 2..8.
- GNT_W, $clog2(N_REQ), width of the grant index (derived, not overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  N_REQ  per-requester read request; held high until that requester's resp_valid.
- req_addr  input  N_REQ*ADDR_WIDTH  packed request addresses; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- resp_valid  output  N_REQ  one-hot, one-cycle response strobe.
- resp_data  output  DATA_WIDTH  response data, shared by all requesters; meaningful only while a resp_valid bit is high.
- busy  output  1  high in any state other than IDLE.
- gnt_id  output  GNT_W  index of the current or last granted requester.
- mem_read_addr  output  ADDR_WIDTH  registered memory address, low 3 bits forced to 0.
- mem_read_valid  output  1  registered memory request.
- mem_read_data  input  DATA_WIDTH  memory data; valid in the cycle mem_read_ready is high.
- mem_read_ready  input  1  memory accept plus data-return strobe.

Behaviour:
- Reset values: state=IDLE; resp_valid=0; resp_data=0; busy=0; gnt_id=0; mem_read_addr=0; mem_read_valid=0; rr pointer=0.
  - Reset is asynchronous and legal mid-transaction: it drops the in-flight request with no response.
  - Memory must tolerate an abandoned request.
- FSM states:
  - IDLE:
    - If any req_valid bit is high, pick a winner per the arbitration rule.
    - Register gnt_id=winner, mem_read_addr={req_addr[winner][ADDR_WIDTH-1:3],3'b000}, mem_read_valid=1.
    - Go to ISSUE.
    - With no request, stay in IDLE with mem_read_valid=0.
  - ISSUE:
    - mem_read_valid stays high and mem_read_addr stays stable until the memory responds.
    - On mem_read_ready=1: capture mem_read_data into resp_data, set resp_valid[gnt_id]=1, clear mem_read_valid, go to RESP.
    - mem_read_ready is ignored in IDLE and RESP.
  - RESP:
    - resp_valid is high for exactly this one cycle.
    - Next cycle: resp_valid=0, go to IDLE.
    - No arbitration happens in RESP, so one bubble cycle separates transactions.
- Latency:
  - Request seen in IDLE at edge N gives mem_read_valid=1 in cycle N+1.
  - Ready at edge M gives resp_valid in cycle M+1.
  - Minimum back-to-back issue spacing is 3 cycles when ready returns immediately.
- Arbitration (default, fixed priority): the highest index wins, so dcache beats icache.
- Request withdrawal: if the granted requester drops req_valid after grant, the transaction still completes and resp_valid is still pulsed. Non-granted requesters may change addresses freely.
- Simultaneous events: a new req_valid arriving while busy waits; it is arbitrated on the first IDLE cycle.
- Address offset: req_addr bits [2:0] are discarded; the response is always the full aligned 8-byte beat.
- Assertions (simulation only):
  - resp_valid is one-hot or zero.
  - mem_read_addr is stable while in ISSUE.
  - No resp_valid in two consecutive cycles.

Optional Feature:
- Macro: MEM_READ_ARBITER_RR_EN.
- Defined: round-robin arbitration.
  - An rr pointer holds the last granted index.
  - The search starts at (rr+1) mod N_REQ, ascending with wrap.
  - rr is updated to the winner on each grant.
  - After reset rr=0, so on the first tie port 1 wins.
- Undefined: fixed priority as described under Behaviour; the rr pointer is not implemented.

Test Plan:
- Reset, then req_valid=2'b01, req_addr[0]=64'h1004:
  - mem_read_valid=1 with mem_read_addr=64'h1000 the next cycle.
  - Ready held low 5 cycles, then pulsed with data 64'hDEAD_BEEF.
  - resp_valid=2'b01 and resp_data=64'hDEAD_BEEF for exactly one cycle.
- Both requesting, addresses 64'h2000 (port 0) and 64'h3000 (port 1), fixed priority:
  - Port 1 is served first.
  - Port 0 is issued 1 bubble cycle after its RESP, at 64'h2000.
  - gnt_id sequence is 1, 0.
- RR_EN build, both held requesting for 4 transactions with ready returning immediately:
  - Grant order is 1, 0, 1, 0.
  - Issue spacing is 3 cycles.
- Granted requester drops req_valid during ISSUE:
  - mem_read_addr stays stable.
  - resp_valid is still pulsed on its bit after ready.
- Reset asserted mid-ISSUE:
  - All outputs reach their reset values immediately.
  - No resp_valid pulse.
  - After reset release, a fresh request issues normally.
- mem_read_ready pulsed high while in IDLE with no requests:
  - No resp_valid.
  - State remains IDLE.
